even_parity_checker: RTL and testbench

//   Even-parity checker for a 4-bit data nibble {a,b,c,d} with an even-parity bit p.
//   pec is combinational and flags a parity error: an odd number of 1s across the 5 bits.
//   A clocked monitor registers each qualified check, keeps a saturating error count
//   and holds a sticky error flag. It sits at the receive side of a nibble link.

---
 rtl/even_parity_checker.sv | 59 +++++
 tb/tb_even_parity_checker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/even_parity_checker.sv
// Even-parity checker for a 4-bit nibble plus parity bit, with a registered monitor
// that keeps saturating error/sample counts and a sticky error flag.
module even_parity_checker #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             p,
  input  logic             valid_in,
  input  logic             clr,
  output logic             pec,
  output logic             pec_q,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] smp_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  assign pec = a ^ b ^ c ^ d ^ p;

  // pec_q follows every qualified sample, including one taken on a clr edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pec_q <= 1'b0;
    end else if (valid_in) begin
      pec_q <= pec;
    end
  end

  // clr wins over valid_in; err_cnt only advances alongside smp_cnt so err_cnt <= smp_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
      smp_cnt    <= '0;
    end else if (clr) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
      smp_cnt    <= '0;
    end else if (valid_in) begin
      if (smp_cnt != CNT_MAX) begin
        smp_cnt <= smp_cnt + CNT_ONE;
      end
      if (pec) begin
        err_sticky <= 1'b1;
        if (err_cnt != CNT_MAX) begin
          err_cnt <= err_cnt + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_even_parity_checker.sv
// Self-checking bench for even_parity_checker: parity table, directed sequences
// and randomized traffic against a counting reference model.
module tb_even_parity_checker;

  localparam int unsigned CNT_W   = 8;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             a, b, c, d, p;
  logic             valid_in;
  logic             clr;
  logic             pec;
  logic             pec_q;
  logic             err_sticky;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] smp_cnt;

  int checks;
  int failures;

  int   m_smp;
  int   m_err;
  logic m_sticky;
  logic m_pecq;

  typedef struct {
    logic [4:0] bits;
    logic       pec;
  } vec_t;

  vec_t tbl[5];

  even_parity_checker #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .p          (p),
    .valid_in   (valid_in),
    .clr        (clr),
    .pec        (pec),
    .pec_q      (pec_q),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt),
    .smp_cnt    (smp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_par(input logic [4:0] v);
    return ($countones(v) % 2) == 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_bits(input logic [4:0] v);
    {a, b, c, d, p} = v;
  endtask

  task automatic model_reset();
    m_smp = 0; m_err = 0; m_sticky = 1'b0; m_pecq = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".pec_q"},      {31'd0, pec_q},      {31'd0, m_pecq});
    check({tag, ".err_sticky"}, {31'd0, err_sticky}, {31'd0, m_sticky});
    check({tag, ".err_cnt"},    {24'd0, err_cnt},    m_err);
    check({tag, ".smp_cnt"},    {24'd0, smp_cnt},    m_smp);
  endtask

  // One clock: drive on the falling edge, update the model at the rising edge, compare 1 ns later.
  task automatic cycle(input logic [4:0] v, input logic vld, input logic cl, input string tag);
    @(negedge clk);
    set_bits(v);
    valid_in = vld;
    clr      = cl;
    @(posedge clk);
    if (vld) m_pecq = ref_par(v);
    if (cl) begin
      m_smp = 0; m_err = 0; m_sticky = 1'b0;
    end else if (vld) begin
      if (m_smp < CNT_MAX) m_smp++;
      if (ref_par(v)) begin
        m_sticky = 1'b1;
        if (m_err < CNT_MAX) m_err++;
      end
    end
    #1;
    check({tag, ".pec"}, {31'd0, pec}, {31'd0, ref_par(v)});
    check_regs(tag);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] v;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    clr      = 1'b0;
    set_bits(5'b00000);
    model_reset();

    // Reset state
    #12;
    check_regs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Table of documented parity examples
    tbl[0] = '{5'b00000, 1'b0};
    tbl[1] = '{5'b00001, 1'b1};
    tbl[2] = '{5'b00011, 1'b0};
    tbl[3] = '{5'b11111, 1'b1};
    tbl[4] = '{5'b10110, 1'b1};
    for (int unsigned i = 0; i < 5; i++) begin
      set_bits(tbl[i].bits);
      #1;
      check("table.pec", {31'd0, pec}, {31'd0, tbl[i].pec});
    end

    // Exhaustive sweep with valid_in low: registers must not move
    for (int unsigned i = 0; i < 32; i++) begin
      v = i[4:0];
      set_bits(v);
      #20;
      check("sweep.pec", {31'd0, pec}, {31'd0, ref_par(v)});
    end
    check_regs("sweep");

    // Reset then three samples: err, ok, err
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(5'b10011, 1'b1, 1'b0, "seq1");
    cycle(5'b11000, 1'b1, 1'b0, "seq2");
    cycle(5'b01000, 1'b1, 1'b0, "seq3");
    check("seq.smp_cnt", {24'd0, smp_cnt}, 32'd3);
    check("seq.err_cnt", {24'd0, err_cnt}, 32'd2);
    check("seq.sticky",  {31'd0, err_sticky}, 32'd1);
    check("seq.pec_q",   {31'd0, pec_q}, 32'd1);

    // Error sample, then clr together with a valid error sample
    cycle(5'b00001, 1'b1, 1'b0, "clr_pre");
    cycle(5'b00111, 1'b1, 1'b1, "clr");
    check("clr.err_cnt", {24'd0, err_cnt}, 32'd0);
    check("clr.smp_cnt", {24'd0, smp_cnt}, 32'd0);
    check("clr.sticky",  {31'd0, err_sticky}, 32'd0);
    check("clr.pec_q",   {31'd0, pec_q}, 32'd1);
    cycle(5'b00000, 1'b0, 1'b0, "clr_hold");

    // Saturation: 300 consecutive error samples
    for (int unsigned i = 0; i < 300; i++) begin
      cycle(5'b10000, 1'b1, 1'b0, "sat");
      check("sat.order", {31'd0, (err_cnt <= smp_cnt)}, 32'd1);
    end
    check("sat.err_cnt", {24'd0, err_cnt}, 32'd255);
    check("sat.smp_cnt", {24'd0, smp_cnt}, 32'd255);
    cycle(5'b00000, 1'b1, 1'b0, "sat_ok");

    // Randomized traffic against the reference model
    cycle(5'b00000, 1'b0, 1'b1, "rnd_clr");
    for (int unsigned i = 0; i < 400; i++) begin
      cycle(5'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 39) == 0), "rnd");
    end

    // Asynchronous reset between edges with err_cnt=5
    cycle(5'b00000, 1'b0, 1'b1, "async_clr");
    for (int unsigned i = 0; i < 5; i++) cycle(5'b01110, 1'b1, 1'b0, "async_fill");
    check("async.pre_err", {24'd0, err_cnt}, 32'd5);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_regs("async");
    set_bits(5'b00100);
    #1;
    check("async.pec1", {31'd0, pec}, 32'd1);
    set_bits(5'b00101);
    #1;
    check("async.pec0", {31'd0, pec}, 32'd0);
    valid_in = 1'b1;
    set_bits(5'b00001);
    @(posedge clk);
    #1;
    check_regs("async_held");
    @(negedge clk);
    rst_n    = 1'b1;
    valid_in = 1'b0;
    cycle(5'b00001, 1'b1, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
